// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Holds the segment bit order, the all-off constants and the active-low hex
// glyph table used by the decoder.
package seven_seg_pkg;

  // Segment vectors are 7 bits wide and ordered {g,f,e,d,c,b,a}, so bit 0 is a.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low glyphs for 0-9 and A, b, C, d, E, F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-digit to 7-segment decoder.
// Ports:
//   i_hex  - 4-bit digit value (0-15)
//   o_seg  - active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit 7-segment display driver.
// Takes a snapshot of the four digits and their decimal points once per
// frame. It then steps through the digits, one slot of REFRESH_N cycles
// each. Each slot opens with GUARD dead cycles so one digit cannot ghost
// into the next. Leading zeros can be blanked, and the whole display can
// be forced off.
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   d3..d0            - digit values (d3 leftmost), 0-15 shown as 0-9/A-F
//   dp_in             - decimal-point request, bit i for digit i
//   lzb               - leading-zero blanking enable (live)
//   blank             - force all anodes off (live)
//   an                - active-low anode enables, bit i for digit i
//   seg               - active-low segments {g,f,e,d,c,b,a}
//   dp                - active-low decimal point
//   frame_tick        - one-cycle pulse when a new snapshot takes effect
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_N = 50000,
  parameter int GUARD     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  input  logic       lzb,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_N > 1) ? $clog2(REFRESH_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_N - 1);

  logic [CW-1:0]    r_count;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_digits;
  logic [3:0]       r_dp;

  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_upper_zero;
  logic             w_blanked;
  logic [6:0]       w_seg;

  assign w_slot_end  = (r_count == LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

  // Leading-zero test: the current digit and every digit to its left are 0.
  // NOTE: give every always_comb output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(r_idx) && r_digits[j] != 4'd0) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never zero-blanked, so a value of 0 still shows "0".
  assign w_blanked = (int'(r_count) < GUARD) || blank ||
                     (lzb && (r_idx != 2'd0) && w_upper_zero);

  hex_to_7seg u_dec (
    .i_hex (r_digits[r_idx]),
    .o_seg (w_seg)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow digits are reset too. The first frame after reset
      // must show a defined 0 rather than whatever the flops powered up as.
      r_count    <= '0;
      r_idx      <= 2'd0;
      r_digits   <= '0;
      r_dp       <= 4'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_count <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_count <= r_count + 1'b1;
      end

      // Inputs are captured only at the frame boundary, so a frame never tears.
      if (w_frame_end) begin
        r_digits <= {d3, d2, d1, d0};
        r_dp     <= dp_in;
      end
      frame_tick <= w_frame_end;

      if (w_blanked) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << r_idx);
        seg <= w_seg;
        dp  <= ~r_dp[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (REFRESH_N = 4, GUARD = 1).
// The reference derives the slot position from the number of cycles since
// reset. It keeps the snapshot as a plain array and predicts every output
// for every cycle.
module tb_seven_seg_scan;

  localparam int N = 4;
  localparam int G = 1;
  localparam int FRAME = 4 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d3, d2, d1, d0, dp_in;
  logic       lzb, blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;

  always #5 clk = ~clk;

  seven_seg_scan #(.REFRESH_N(N), .GUARD(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dp_in      (dp_in),
    .lzb        (lzb),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: cycles since reset release and the displayed snapshot.
  int         t = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got=%0b expected=%0b", tag, $time, got, exp);
    end
  endtask

  // One clock: predict from pre-edge state and inputs, then compare and update.
  task automatic tick();
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e, ft_e, bl, all_zero, rst_s;
    logic [3:0] in_d [4];
    logic [3:0] in_dp;
    int         p, idx, cnt;
    rst_s = reset;
    in_d[0] = d0; in_d[1] = d1; in_d[2] = d2; in_d[3] = d3;
    in_dp = dp_in;
    p = t % FRAME;
    idx = p / N;
    cnt = p % N;
    an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1; ft_e = 1'b0;
    if (!rst_s) begin
      all_zero = 1'b1;
      for (int j = idx; j < 4; j++) if (m_dig[j] != 4'd0) all_zero = 1'b0;
      bl = (cnt < G) || blank || (lzb && idx >= 1 && all_zero);
      if (!bl) begin
        an_e[idx] = 1'b0;
        seg_e = glyph[m_dig[idx]];
        dp_e = ~m_dp[idx];
      end
      ft_e = (p == FRAME - 1);
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(an_e));
    check("seg", 32'(seg), 32'(seg_e));
    check("dp", 32'(dp), 32'(dp_e));
    check("frame_tick", 32'(frame_tick), 32'(ft_e));
    if (rst_s) begin
      t = 0;
      for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
      m_dp = 4'd0;
    end else begin
      if (p == FRAME - 1) begin
        for (int j = 0; j < 4; j++) m_dig[j] = in_d[j];
        m_dp = in_dp;
      end
      t++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
    m_dp = 4'd0;
    reset = 1'b1; lzb = 1'b0; blank = 1'b0; dp_in = 4'd0;
    set_d(4'd1, 4'd2, 4'd3, 4'd4);

    // Reset and first frame: shows 0 everywhere, frame_tick on cycle 16.
    run(3);
    reset = 1'b0;
    run(8);
    // Snapshot/decode: 4,3,2,1 captured, then 9s arrive mid-frame.
    set_d(4'd4, 4'd3, 4'd2, 4'd1);
    run(14);
    set_d(4'd9, 4'd9, 4'd9, 4'd9);
    run(10);
    run(FRAME);

    // Hex glyphs with a decimal point on digit 2.
    set_d(4'hF, 4'hE, 4'hA, 4'hB);
    dp_in = 4'b0100;
    run(2 * FRAME);
    dp_in = 4'd0;

    // Leading-zero blanking.
    lzb = 1'b1;
    set_d(4'd0, 4'd0, 4'd0, 4'd7);
    run(2 * FRAME);
    set_d(4'd0, 4'd0, 4'd0, 4'd0);
    run(2 * FRAME);
    set_d(4'd0, 4'd5, 4'd0, 4'd0);
    run(2 * FRAME);
    lzb = 1'b0;

    // Blank, then a reset pulse mid-slot.
    blank = 1'b1;
    run(6);
    blank = 1'b0;
    run(3);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(2 * FRAME + 3);

    // Randomized traffic: inputs change at random cycles, occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) lzb = ~lzb;
      blank = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    blank = 1'b0;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed 4-digit 7-segment display driver; the display-side consumer of the four 4-bit digit buses produced by the stopwatch/counter blocks. It snapshots the digits once per scan frame, cycles through them at a programmable refresh rate, decodes each to active-low segments and drives the active-low anodes. It adds guard (dead) time against ghosting, leading-zero blanking and per-digit decimal points.

## Interface
- `REFRESH_N`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `GUARD`, default 2: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ GUARD < REFRESH_N.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `d3, d2, d1, d0` in 4 each: digit values (d3 = leftmost). 0–9 BCD; 10–15 are shown as hex A–F.
- `dp_in` in 4: decimal-point request; bit i belongs to digit i.
- `lzb` in 1: leading-zero blanking enable.
- `blank` in 1: forces all anodes off.
- `an` out 4: anode enables, active-low; bit i selects digit i.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `frame_tick` out 1: one-cycle pulse when a new snapshot takes effect.

## Operation
- Registers:
  - `count` is 0..REFRESH_N-1.
  - `idx` is 2 bits, 0..3.
  - `shadow[3:0]` holds the four 4-bit digits plus 4 dp bits.
  - Output registers: `an`, `seg`, `dp`, `frame_tick`.
- Slot advance:
  - When count == REFRESH_N-1: count <= 0 and idx <= idx+1, wrapping 3→0.
  - Otherwise count <= count+1.
- Snapshot:
  - In the cycle where count == REFRESH_N-1 and idx == 3, shadow <= {d3..d0, dp_in}.
  - In the same cycle, frame_tick is registered high for one cycle.
  - Inputs are ignored at all other times, so mid-frame input changes never tear.
- Blanking of the slot for idx = i: the slot is blanked if any of the following holds:
  - count < GUARD;
  - `blank` = 1;
  - `lzb` = 1 and every shadow digit with index ≥ i is 0, for i ≥ 1. Digit 0 is never zero-blanked.
- Output register update each cycle:
  - When blanked: an <= 4'b1111, seg <= 7'b1111111, dp <= 1.
  - Otherwise: an <= ~(4'b0001 << idx), seg <= decode(shadow digit idx), dp <= ~shadow dp bit idx.
- Decode table, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001
  - E = 0000110, F = 0001110
- `lzb` and `blank` are sampled live every cycle; they are not snapshotted.

## Timing
- Reset values (registered outputs):
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
  - Internal: count = 0, idx = 0, shadow = 0.
- First frame after reset displays shadow = 0000 with no dp.
  - The first snapshot happens at cycle 4·REFRESH_N−1 after reset release.
  - frame_tick goes high on the following cycle.
- Output latency: an/seg/dp reflect the idx/count/shadow of the previous cycle (one register stage).
- Frame period: 4·REFRESH_N cycles. Each digit is lit for REFRESH_N−GUARD cycles per frame.
- With GUARD = 0, adjacent slots switch with no dead cycle. an never has more than one bit low.
- Reset asserted mid-frame: all registers take their reset values at that edge. There is no partial-frame carry-over.
- Simultaneous slot wrap and input change: the values present in the snapshot cycle are the ones captured.

## Structure
- Package `seven_seg_pkg` holds:
  - the decode table constants;
  - SEG_OFF = 7'b1111111 and AN_OFF = 4'b1111;
  - the {g..a} bit-order definition.
- Sub-module `hex_to_7seg`: purely combinational, 4-bit in / 7-bit active-low out, using the package constants. It is instantiated once, fed by the muxed shadow digit.
- The top level contains the counter, idx, shadow, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_N = 4 and GUARD = 1.
- Reset/first frame:
  - Stimulus: hold reset 3 cycles with d = 1,2,3,4, then release.
  - Required response: an = 1111 during reset. For 16 cycles the display shows digit "0" (seg = 1000000) on an = 1110, 1101, 1011, 0111 in turn, each lit 3 of 4 cycles. frame_tick pulses once at cycle 16.
- Snapshot/decode:
  - Stimulus: d3..d0 = 4,3,2,1, then change the inputs to 9,9,9,9 mid-frame.
  - Required response: the next frame shows seg 1111001 (1), 0100100 (2), 0110000 (3), 0011001 (4) on an 1110, 1101, 1011, 0111. The value 9 appears only after the following snapshot.
- Hex and dp:
  - Stimulus: d = F,E,A,B with dp_in = 0100.
  - Required response: seg 0000011 (b), 0001000 (A), 0000110 (E), 0001110 (F) for digits 0..3. dp = 0 only while an = 1011.
- Leading-zero blanking:
  - Stimulus: lzb = 1 with d = 0,0,0,7; then d = 0,0,0,0.
  - Required response: only an = 1110 is ever low, showing 1111000 (7), and then 1000000 (0). Digit 0 is never blanked.
- Blank and mid-frame reset:
  - Stimulus: assert blank for 6 cycles, then pulse reset mid-slot.
  - Required response: an = 1111 exactly one cycle after blank rises and for the full duration. After the reset edge: an = 1111, seg = 1111111, and count and idx restart from 0.
